// File: rtl/pipe_pkg.sv
// Shared types and MEM/WB field widths for the pipeline skid-buffer registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int WB_CTRL_W  = 2;
  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEMWB_W    = WB_CTRL_W + 2 * WORD_W + REG_ADDR_W;

  // Order: {RegWrite, MemtoReg, ReadData, ALUResult, RdAddr}
  function automatic logic [MEMWB_W-1:0] pack_memwb(
    input logic                  reg_write,
    input logic                  mem_to_reg,
    input logic [WORD_W-1:0]     read_data,
    input logic [WORD_W-1:0]     alu_result,
    input logic [REG_ADDR_W-1:0] rd_addr
  );
    return {reg_write, mem_to_reg, read_data, alu_result, rd_addr};
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: fully registered ready/valid handshake
// with flush (bubble insertion) and one-cycle latency.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = MEMWB_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  if (DATA_W < 1) begin : g_bad_width
    $error("pipe_skid_reg: DATA_W must be at least 1");
  end

  state_e            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              w_push;
  logic              w_pop;

  // Handshake outputs decode only from state (and reset), never from out_ready_i.
  assign in_ready_o  = (r_state != FULL) & ~rst_i;
  assign out_valid_o = (r_state != EMPTY) & ~rst_i;
  assign occupancy_o = rst_i ? 2'd0 : r_state;
  assign out_data_o  = r_main;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      r_state <= EMPTY;
      if (CLEAR_ON_FLUSH) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_main  <= in_data_i;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            r_skid  <= in_data_i;
            r_state <= FULL;
          end else if (w_push && w_pop) begin
            r_main  <= in_data_i;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          // Skid entry is always younger than main, so it moves up on pop.
          if (w_pop) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus a randomized stall scoreboard for pipe_skid_reg.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int W = MEMWB_W;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] in_data_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [W-1:0] out_data_o;
  logic [1:0]   occupancy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .occupancy_o(occupancy_o)
  );

  typedef struct {
    logic         rst;
    logic         flush;
    logic         vld;
    logic [W-1:0] d;
    logic         rdy;
    logic [1:0]   occ;
    logic         ovld;
    logic         irdy;
    logic [W-1:0] data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic flush, input logic vld,
                     input logic [W-1:0] d, input logic rdy, input logic [1:0] occ,
                     input logic ovld, input logic irdy, input logic [W-1:0] data);
    vec_t v;
    v.rst = rst; v.flush = flush; v.vld = vld; v.d = d; v.rdy = rdy;
    v.occ = occ; v.ovld = ovld; v.irdy = irdy; v.data = data;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] exp_word;
    logic         push;
    logic         pop;

    // Inputs apply before the edge; expectations are the outputs after it.
    //   rst flush vld data  rdy  occ ovld irdy out_data
    add(1, 0, 0, 'h0, 0, 0, 0, 0, 'h0);
    add(1, 0, 0, 'h0, 0, 0, 0, 0, 'h0);
    add(0, 0, 1, 'h1, 1, 1, 1, 1, 'h1);   // streaming
    add(0, 0, 1, 'h2, 1, 1, 1, 1, 'h2);
    add(0, 0, 1, 'h3, 1, 1, 1, 1, 'h3);
    add(0, 0, 1, 'h4, 1, 1, 1, 1, 'h4);
    add(0, 0, 1, 'h5, 1, 1, 1, 1, 'h5);
    add(0, 0, 0, 'h0, 1, 0, 0, 1, 'h5);
    add(0, 0, 1, 'hA, 0, 1, 1, 1, 'hA);   // backpressure
    add(0, 0, 1, 'hB, 0, 2, 1, 0, 'hA);
    add(0, 0, 1, 'hC, 0, 2, 1, 0, 'hA);   // refused while full, head stable
    add(0, 0, 0, 'h0, 1, 1, 1, 1, 'hB);
    add(0, 0, 0, 'h0, 1, 0, 0, 1, 'hB);
    add(0, 0, 1, 'h7, 0, 1, 1, 1, 'h7);   // push+pop in ONE
    add(0, 0, 1, 'h8, 1, 1, 1, 1, 'h8);
    add(0, 0, 0, 'h0, 1, 0, 0, 1, 'h8);
    add(0, 0, 1, 'hA, 0, 1, 1, 1, 'hA);   // flush while full
    add(0, 0, 1, 'hB, 0, 2, 1, 0, 'hA);
    add(0, 1, 1, 'hC, 0, 0, 0, 1, 'h0);
    add(0, 0, 1, 'hD, 0, 1, 1, 1, 'hD);   // flush in ONE drops concurrent push
    add(0, 1, 1, 'hE, 1, 0, 0, 1, 'h0);
    add(0, 0, 0, 'h0, 1, 0, 0, 1, 'h0);
    add(0, 0, 1, 'h1, 0, 1, 1, 1, 'h1);   // reset mid-transfer
    add(0, 0, 1, 'h2, 0, 2, 1, 0, 'h1);
    add(1, 0, 1, 'h9, 0, 0, 0, 0, 'h0);
    add(0, 0, 1, 'h3, 0, 1, 1, 1, 'h3);
    add(0, 0, 0, 'h0, 1, 0, 0, 1, 'h3);
    add(0, 0, 1, 'h4, 0, 1, 1, 1, 'h4);   // reset beats flush
    add(1, 1, 1, 'h6, 0, 0, 0, 0, 'h0);
    add(0, 0, 0, 'h0, 0, 0, 0, 1, 'h0);

    for (int i = 0; i < vq.size(); i++) begin
      rst_i = vq[i].rst; flush_i = vq[i].flush; in_valid_i = vq[i].vld;
      in_data_i = vq[i].d; out_ready_i = vq[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.occupancy", i), W'(occupancy_o), W'(vq[i].occ));
      check($sformatf("v%0d.out_valid", i), W'(out_valid_o), W'(vq[i].ovld));
      check($sformatf("v%0d.in_ready", i), W'(in_ready_o), W'(vq[i].irdy));
      check($sformatf("v%0d.out_data", i), out_data_o, vq[i].data);
    end

    // Random stall scoreboard with MEM/WB-packed payloads.
    rst_i = 1'b0; flush_i = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      in_data_i   = pack_memwb(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
      #1;
      push = in_valid_i & in_ready_o;
      pop  = out_valid_o & out_ready_i;
      if (out_valid_o !== (q.size() != 0)) begin
        check("rand.out_valid", W'(out_valid_o), W'(q.size() != 0));
      end
      if (pop) begin
        if (q.size() == 0) begin
          check("rand.spurious_pop", W'(1), W'(0));
        end else begin
          exp_word = q.pop_front();
          check("rand.order", out_data_o, exp_word);
        end
      end
      if (push) q.push_back(in_data_i);
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    check("rand.occupancy", W'(occupancy_o), W'(q.size()));

    // Drain what remains, bounded.
    out_ready_i = 1'b1;
    for (int c = 0; c < 4 && q.size() != 0; c++) begin
      #1;
      exp_word = q.pop_front();
      check("drain.data", out_data_o, exp_word);
      check("drain.valid", W'(out_valid_o), W'(1));
      @(posedge clk);
      #1;
    end
    check("drain.empty", W'(out_valid_o), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 71, payload width; MEM/WB packing is {RegWrite, MemtoReg, ReadData[31:0], ALUResult[31:0], RdAddr[4:0]}.
REQ-002 Parameter CLEAR_ON_FLUSH, default 1, zeroes both data registers on flush when 1 and leaves them unchanged when 0.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all state SHALL change on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 flush_i  input  1  discards all held entries (bubble insertion).
REQ-007 in_valid_i  input  1  upstream entry valid.
REQ-008 in_ready_o  output  1  block can accept an entry.
REQ-009 in_data_i  input  DATA_W  upstream payload.
REQ-010 out_valid_o  output  1  out_data_o holds a valid entry.
REQ-011 out_ready_i  input  1  downstream accepts the entry.
REQ-012 out_data_o  output  DATA_W  head payload.
REQ-013 occupancy_o  output  2  held entry count, 0 to 2.

Function
REQ-014 push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i; both SHALL be evaluated in the same cycle.
REQ-015 States are EMPTY, ONE and FULL; occupancy_o SHALL equal 0, 1 or 2 respectively.
REQ-016 in_ready_o SHALL equal (state != FULL) & ~rst_i, decoded from registers only; there SHALL be no combinational path from out_ready_i.
REQ-017 out_valid_o SHALL equal (state != EMPTY); out_data_o SHALL be driven directly from the main register.
REQ-018 EMPTY: on push, main <= in_data_i and the next state is ONE; otherwise the state is held.
REQ-019 ONE: push & ~pop -> skid <= in_data_i, next state FULL; push & pop -> main <= in_data_i, stay ONE; ~push & pop -> EMPTY; neither -> hold.
REQ-020 FULL: on pop, main <= skid and the next state is ONE; otherwise hold. No push is possible because in_ready_o = 0.
REQ-021 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_data_o after edge N.
REQ-022 Throughput SHALL be one entry per cycle whenever out_ready_i stays high.
REQ-023 Order SHALL be FIFO: the skid entry is never presented before the main entry.
REQ-024 Data in main and skid SHALL stay stable while unpopped; out_data_o SHALL not change while out_valid_o & ~out_ready_i.
REQ-025 flush_i SHALL override push and pop: next state EMPTY, and any push in the flush cycle is dropped.
REQ-026 On flush, the data registers SHALL be zeroed when CLEAR_ON_FLUSH = 1 and left unchanged when it is 0.
REQ-027 When rst_i and flush_i are both high, reset SHALL take priority.
REQ-028 Unregistered input X values SHALL not propagate into the state.

Reset
REQ-029 When rst_i is high at a clock edge: state <= EMPTY, main <= 0, skid <= 0.
REQ-030 While rst_i is high: out_valid_o = 0, in_ready_o = 0, occupancy_o = 0.
REQ-031 Reset asserted mid-transfer SHALL discard all entries; the first push accepted is the first one after rst_i deasserts.
REQ-032 No asynchronous reset or set SHALL be present.

Structure
REQ-033 Package pipe_pkg SHALL hold the state typedef (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2).
REQ-034 pipe_pkg SHALL also hold the MEM/WB field width constants: WB_CTRL_W = 2, WORD_W = 32, REG_ADDR_W = 5, MEMWB_W = 71.
REQ-035 The block SHALL contain no sub-module; main and skid are inline registers. Instances for IF/ID, ID/EX, EX/MEM and MEM/WB differ only in DATA_W.
REQ-036 An elaboration-time check SHALL reject DATA_W < 1.

Verification
REQ-037 Streaming: reset for 2 cycles, then push 0x1..0x5 on consecutive cycles with out_ready_i = 1 -> out_data_o = 0x1..0x5 one cycle later each, and occupancy_o never exceeds 1.
REQ-038 Backpressure: out_ready_i = 0, push 0xA then 0xB -> occupancy 2 and in_ready_o = 0; raise out_ready_i -> output 0xA then 0xB, and in_ready_o = 1 one cycle after the first pop.
REQ-039 Simultaneous push and pop in ONE holding 0x7, with input 0x8 -> next cycle out_data_o = 0x8 and occupancy stays 1.
REQ-040 Flush while FULL (0xA, 0xB) with a concurrent push of 0xC -> next cycle occupancy 0, out_valid_o = 0, out_data_o = 0 (CLEAR_ON_FLUSH = 1); 0xC is never output.
REQ-041 Mid-operation reset with occupancy 2 -> after the edge occupancy 0, in_ready_o = 0 during reset and 1 after deassertion; the next push of 0x3 appears alone.
REQ-042 Random stall scoreboard with DATA_W = 71 and MEM/WB-packed payloads, 10k cycles -> no loss, duplication or reordering.
